// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: EX-stage inputs, IF redirect handshake and status outputs; master = pipeline side, slave = branch_resolve_unit
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic             cond_taken;
  logic             pred_taken;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs1;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             misalign_exc;
  logic [CNT_W-1:0] mispredict_cnt;
  modport master (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, cond_taken, pred_taken,
           ex_pc, ex_imm, ex_rs1, redirect_ready,
    input  ex_ready, redirect_valid, redirect_pc, flush, misalign_exc, mispredict_cnt
  );
  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, cond_taken, pred_taken,
           ex_pc, ex_imm, ex_rs1, redirect_ready,
    output ex_ready, redirect_valid, redirect_pc, flush, misalign_exc, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX control transfers, redirects IF on mispredict, flushes, flags misaligned targets; ports clk, rst, bus (slave)
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [XLEN-1:0]  rpc_q, rpc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exc_q, exc_d;
  logic [XLEN-1:0]  target, next_pc;
  logic             accept, ctrl, taken, misalign, mispredict;
  always_comb begin
    accept     = bus.ex_valid & (state_q == IDLE);
    ctrl       = bus.ex_is_branch | bus.ex_is_jal | bus.ex_is_jalr;
    taken      = bus.ex_is_jal | bus.ex_is_jalr | (bus.ex_is_branch & bus.cond_taken);
    target     = bus.ex_is_jalr ? (bus.ex_rs1 + bus.ex_imm) & ~XLEN'(1) : bus.ex_pc + bus.ex_imm;
    next_pc    = taken ? target : bus.ex_pc + XLEN'(4);
    misalign   = ctrl & taken & (|target[1:0]);
    mispredict = ctrl & ((taken != bus.pred_taken) | bus.ex_is_jalr);
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    rpc_d      = rpc_q;
    cnt_d      = cnt_q;
    exc_d      = 1'b0;
    case (state_q)
      IDLE:
        if (accept & misalign) begin
          state_d = FLUSH;
          fcnt_d  = FW'(FLUSH_CYCLES);
          exc_d   = 1'b1;
        end else if (accept & mispredict) begin
          state_d = REDIRECT;
          rpc_d   = next_pc;
          cnt_d   = cnt_q + CNT_W'(cnt_q != '1);
        end
      REDIRECT:
        if (bus.redirect_ready) begin
          state_d = FLUSH;
          fcnt_d  = FW'(FLUSH_CYCLES);
        end
      FLUSH: begin
        fcnt_d  = fcnt_q - FW'(1);
        state_d = (fcnt_q == FW'(1)) ? IDLE : FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      rpc_q   <= '0;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end
  assign bus.ex_ready       = state_q == IDLE;
  assign bus.redirect_valid = state_q == REDIRECT;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush          = state_q != IDLE;
  assign bus.misalign_exc   = exc_q;
  assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table vectors, corner sequences and random stimulus against a cycle model
module tb_branch_resolve_unit;
  localparam int F = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) b0 ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  b1 ();
  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(F), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(F), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  assign b1.ex_valid       = b0.ex_valid;
  assign b1.ex_is_branch   = b0.ex_is_branch;
  assign b1.ex_is_jal      = b0.ex_is_jal;
  assign b1.ex_is_jalr     = b0.ex_is_jalr;
  assign b1.cond_taken     = b0.cond_taken;
  assign b1.pred_taken     = b0.pred_taken;
  assign b1.ex_pc          = b0.ex_pc;
  assign b1.ex_imm         = b0.ex_imm;
  assign b1.ex_rs1         = b0.ex_rs1;
  assign b1.redirect_ready = b0.redirect_ready;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what the instruction architecturally does
  logic [31:0] r_tgt, r_npc;
  bit          r_tk, r_ctl, r_mal, r_mis;
  always_comb begin
    r_ctl = b0.ex_is_branch || b0.ex_is_jal || b0.ex_is_jalr;
    r_tk  = b0.ex_is_jalr || b0.ex_is_jal || (b0.ex_is_branch && b0.cond_taken);
    r_tgt = b0.ex_is_jalr ? ((b0.ex_rs1 + b0.ex_imm) >> 1) << 1 : b0.ex_pc + b0.ex_imm;
    r_npc = r_tk ? r_tgt : b0.ex_pc + 32'd4;
    r_mal = r_ctl && r_tk && (r_tgt % 4 != 0);
    r_mis = r_ctl && (b0.ex_is_jalr || (r_tk != b0.pred_taken));
  end

  // Cycle model: pending redirect flag plus remaining flush cycles
  bit          m_live = 0, m_redir = 0, m_exc = 0;
  logic [31:0] m_pc = 0;
  int          m_left = 0, m_cnt0 = 0, m_cnt1 = 0;
  always @(posedge clk) begin
    m_live <= 1;
    if (rst) begin
      m_redir <= 0; m_pc <= 0; m_left <= 0; m_cnt0 <= 0; m_cnt1 <= 0; m_exc <= 0;
    end else begin
      m_exc <= 0;
      if (m_redir) begin
        if (b0.redirect_ready) begin
          m_redir <= 0;
          m_left  <= F;
        end
      end else if (m_left > 0) m_left <= m_left - 1;
      else if (b0.ex_valid && r_mal) begin
        m_exc  <= 1;
        m_left <= F;
      end else if (b0.ex_valid && r_mis) begin
        m_redir <= 1;
        m_pc    <= r_npc;
        m_cnt0  <= (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
        m_cnt1  <= (m_cnt1 < 3) ? m_cnt1 + 1 : m_cnt1;
      end
    end
  end
  always @(negedge clk) begin
    if (m_live) begin
      chk("model ex_ready", 32'(b0.ex_ready), 32'(!m_redir && m_left == 0));
      chk("model redirect_valid", 32'(b0.redirect_valid), 32'(m_redir));
      chk("model flush", 32'(b0.flush), 32'(m_redir || m_left > 0));
      chk("model misalign_exc", 32'(b0.misalign_exc), 32'(m_exc));
      chk("model redirect_pc", b0.redirect_pc, m_pc);
      chk("model mispredict_cnt", 32'(b0.mispredict_cnt), 32'(m_cnt0));
      chk("model cnt_sat", 32'(b1.mispredict_cnt), 32'(m_cnt1));
    end
  end

  task automatic drive(bit v, bit br, bit jal, bit jalr, bit cond, bit pred,
                       logic [31:0] pc, logic [31:0] imm, logic [31:0] rs1, bit rdy);
    b0.ex_valid = v; b0.ex_is_branch = br; b0.ex_is_jal = jal; b0.ex_is_jalr = jalr;
    b0.cond_taken = cond; b0.pred_taken = pred; b0.ex_pc = pc; b0.ex_imm = imm;
    b0.ex_rs1 = rs1; b0.redirect_ready = rdy;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && !b0.ex_ready; k++) @(negedge clk);
    chk("idle timeout", 32'(b0.ex_ready), 32'd1);
  endtask

  typedef struct {
    bit br, jal, jalr, cond, pred;
    logic [31:0] pc, imm, rs1;
    bit e_redir;
    logic [31:0] e_pc;
    bit e_mal;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1,0,0,0,0, 32'h100, 32'h0, 32'h0, 0, 32'h0, 0};
    tbl[1]  = '{1,0,0,1,0, 32'h100, 32'h20, 32'h0, 1, 32'h120, 0};
    tbl[2]  = '{1,0,0,0,1, 32'hFFFFFFFC, 32'h20, 32'h0, 1, 32'h0, 0};
    tbl[3]  = '{0,0,1,0,1, 32'h400, 32'h0, 32'h1003, 0, 32'h0, 1};
    tbl[4]  = '{0,0,1,0,1, 32'h400, 32'h0, 32'h1001, 1, 32'h1000, 0};
    tbl[5]  = '{0,1,0,0,1, 32'h200, 32'h40, 32'h0, 0, 32'h0, 0};
    tbl[6]  = '{0,1,0,0,0, 32'h200, 32'hFFFFFFF8, 32'h0, 1, 32'h1F8, 0};
    tbl[7]  = '{0,0,0,1,1, 32'h300, 32'h7, 32'h0, 0, 32'h0, 0};
    tbl[8]  = '{1,0,0,1,1, 32'h100, 32'h6, 32'h0, 0, 32'h0, 1};
    tbl[9]  = '{1,1,1,0,1, 32'h500, 32'h4, 32'h3000, 1, 32'h3004, 0};
    tbl[10] = '{1,0,0,0,1, 32'h100, 32'h6, 32'h0, 1, 32'h104, 0};
    drive(0,0,0,0,0,0, 0,0,0, 0);
    repeat (2) @(negedge clk);
    chk("reset ex_ready", 32'(b0.ex_ready), 32'd1);
    chk("reset redirect_valid", 32'(b0.redirect_valid), 32'd0);
    chk("reset flush", 32'(b0.flush), 32'd0);
    chk("reset redirect_pc", b0.redirect_pc, 32'd0);
    chk("reset cnt", 32'(b0.mispredict_cnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wait_idle();
      drive(1, tbl[i].br, tbl[i].jal, tbl[i].jalr, tbl[i].cond, tbl[i].pred,
            tbl[i].pc, tbl[i].imm, tbl[i].rs1, 1);
      @(negedge clk);
      b0.ex_valid = 0;
      chk($sformatf("vec%0d redirect_valid", i), 32'(b0.redirect_valid), 32'(tbl[i].e_redir));
      chk($sformatf("vec%0d misalign_exc", i), 32'(b0.misalign_exc), 32'(tbl[i].e_mal));
      if (tbl[i].e_redir) chk($sformatf("vec%0d redirect_pc", i), b0.redirect_pc, tbl[i].e_pc);
    end
    // Redirect held for three cycles, then handshake and flush tail
    wait_idle();
    drive(1,1,0,0,1,0, 32'h100, 32'h20, 0, 0);
    @(negedge clk);
    b0.ex_valid = 0;
    for (int j = 0; j < 3; j++) begin
      chk("hold redirect_valid", 32'(b0.redirect_valid), 32'd1);
      chk("hold redirect_pc", b0.redirect_pc, 32'h120);
      chk("hold ex_ready", 32'(b0.ex_ready), 32'd0);
      if (j == 2) b0.redirect_ready = 1;
      @(negedge clk);
    end
    b0.redirect_ready = 0;
    for (int j = 0; j < F; j++) begin
      chk("tail flush", 32'(b0.flush), 32'd1);
      chk("tail redirect_valid", 32'(b0.redirect_valid), 32'd0);
      chk("tail ex_ready", 32'(b0.ex_ready), 32'd0);
      @(negedge clk);
    end
    chk("tail idle", 32'(b0.ex_ready), 32'd1);
    chk("tail flush off", 32'(b0.flush), 32'd0);
    // Reset in the middle of a pending redirect
    drive(1,1,0,0,1,0, 32'h100, 32'h20, 0, 0);
    @(negedge clk);
    b0.ex_valid = 0;
    chk("prereset redirect_valid", 32'(b0.redirect_valid), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset redirect_valid", 32'(b0.redirect_valid), 32'd0);
    chk("midreset flush", 32'(b0.flush), 32'd0);
    chk("midreset cnt", 32'(b0.mispredict_cnt), 32'd0);
    chk("midreset ex_ready", 32'(b0.ex_ready), 32'd1);
    rst = 1'b0;
    // Five mispredicts saturate a 2-bit counter
    for (int j = 0; j < 5; j++) begin
      wait_idle();
      drive(1,1,0,0,1,0, 32'h100 + 32'(j * 16), 32'h20, 0, 1);
      @(negedge clk);
      b0.ex_valid = 0;
    end
    wait_idle();
    chk("sat cnt2", 32'(b1.mispredict_cnt), 32'd3);
    chk("sat cnt16", 32'(b0.mispredict_cnt), 32'd5);
    // Back-to-back correctly predicted / non-control instructions
    for (int j = 0; j < 6; j++) begin
      drive(1, j % 3 == 0, j % 3 == 1, 0, 0, j % 3 == 1, 32'h800 + 32'(j * 4), 32'h10, 0, 0);
      @(negedge clk);
      chk("b2b ex_ready", 32'(b0.ex_ready), 32'd1);
    end
    b0.ex_valid = 0;
    // Random traffic against the cycle model
    for (int j = 0; j < 3000; j++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom), $urandom & 32'hFFFFFFFC,
            ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0000FFFC) - 32'h8000,
            $urandom, 1'($urandom));
      @(negedge clk);
    end
    b0.ex_valid = 0;
    b0.redirect_ready = 1;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution and PC-redirect controller for the RV32I pipeline. Consumes the `taken` result of the branch comparator ops (Beq/Bne/Blt/…) plus jump flags, computes the architecturally correct next PC, and compares it with the fetch-stage prediction. On mismatch it issues a ready/valid redirect to IF, then flushes younger pipeline stages for a fixed number of cycles, stalling EX meanwhile. It also flags misaligned control-transfer targets and counts mispredictions.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- FLUSH_CYCLES, 2, flush cycles after redirect handshake (≥1)
- CNT_W, 16, mispredict counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX slot holds an instruction
- ex_ready  out  1  unit accepts EX instruction this cycle
- ex_is_branch  in  1  conditional branch
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- cond_taken  in  1  comparator op result (e.g. Bne `taken`)
- pred_taken  in  1  fetch-stage prediction for this instruction
- ex_pc  in  XLEN  instruction PC
- ex_imm  in  XLEN  sign-extended immediate
- ex_rs1  in  XLEN  rs1 value (JALR base)
- redirect_valid  out  1  redirect request to IF
- redirect_ready  in  1  IF accepts redirect
- redirect_pc  out  XLEN  correct next PC
- flush  out  1  kill IF/ID and ID/EX contents
- misalign_exc  out  1  one-cycle misaligned-target pulse
- mispredict_cnt  out  CNT_W  saturating mispredict count

## Operation
- Accept = ex_valid & ex_ready; ex_ready = (state == IDLE). Nothing is sampled when not accepted.
- Kind priority when several flags set: jalr > jal > branch; no flag = non-control, no action.
- actual_taken = jal | jalr | (branch & cond_taken).
- Target: branch/jal = ex_pc + ex_imm; jalr = (ex_rs1 + ex_imm) & ~1. All adds modulo 2^XLEN (wrap, no carry out).
- next_pc = actual_taken ? target : ex_pc + 4.
- Mispredict = control instr & (actual_taken != pred_taken, or jalr). JALR always redirects (no target prediction).
- Misaligned = actual_taken & target[1:0] != 0. Takes precedence over mispredict: no redirect, misalign_exc pulses, flush sequence runs, counter unchanged.
- States: IDLE, REDIRECT, FLUSH.
  - IDLE → REDIRECT on accepted mispredict (redirect_pc latched = next_pc, counter +1).
  - IDLE → FLUSH on accepted misaligned (flush counter loaded FLUSH_CYCLES).
  - REDIRECT → FLUSH when redirect_ready = 1 (handshake completes that cycle).
  - FLUSH → IDLE after FLUSH_CYCLES cycles in FLUSH.
- redirect_valid = (state == REDIRECT); redirect_pc stable while valid. flush = (state ∈ {REDIRECT, FLUSH}).
- mispredict_cnt saturates at all-ones; never wraps.

## Timing
- Reset (rst high at edge): state IDLE, redirect_valid 0, redirect_pc 0, flush 0, misalign_exc 0, mispredict_cnt 0, flush counter 0; ex_ready 1 after reset.
- Mispredict accepted at cycle N: cycle N+1 redirect_valid=1, flush=1, ex_ready=0, counter visible incremented.
- redirect_ready high in cycle M (M≥N+1): cycles M+1..M+FLUSH_CYCLES flush=1, redirect_valid=0; ex_ready=1 at M+FLUSH_CYCLES+1.
- Minimum stall for mispredict with immediate ready: 1+FLUSH_CYCLES cycles.
- redirect_ready while not in REDIRECT ignored.
- Misaligned accepted at N: misalign_exc=1 only in N+1; flush N+1..N+FLUSH_CYCLES; IDLE at N+FLUSH_CYCLES+1.
- Correct prediction or non-control: no state change, ex_ready stays 1, back-to-back accepts every cycle.
- rst mid-REDIRECT/FLUSH: next cycle all outputs at reset values; pending redirect discarded.

## Test plan
- Reset: hold rst 2 cycles mid-REDIRECT → redirect_valid 0, flush 0, mispredict_cnt 0, ex_ready 1.
- BNE not-taken correctly predicted: branch, cond_taken=0, pred_taken=0, pc=0x100 → no redirect, ex_ready stays 1, count 0.
- BNE taken mispredicted: pc=0x100, imm=0x20, cond_taken=1, pred_taken=0, redirect_ready held low 3 cycles → redirect_valid 1 with redirect_pc=0x120 stable 3 cycles; ready high → 2 flush cycles, then IDLE; count 1.
- Branch predicted taken but not: pc=0xFFFFFFFC, pred_taken=1, cond_taken=0 → redirect_pc=0x00000000 (wrap).
- JALR: rs1=0x1003, imm=0 → redirect_pc 0x1002 → misaligned: misalign_exc one-cycle pulse, no redirect_valid, flush 2 cycles, count unchanged; rs1=0x1001 → redirect_pc 0x1000, redirect issued.
- Counter saturation with CNT_W=2: 5 mispredicts → mispredict_cnt 3.
